uart_rx_ctrl: RTL and testbench



---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_ctrl_if.sv | 23 ++
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_rx_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding, parity selects and the baud divisor helper.
package uart_pkg;

  localparam int DATA_BITS = 8;

  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_e;

  // Clock cycles per oversample tick, rounded to nearest.
  function automatic int baud_div(input int clk_hz, input int baud, input int oversample);
    int den;
    den = baud * oversample;
    return (clk_hz + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// CPU/line side bundle of the UART receiver; master drives the line and read strobe, slave is the receiver.
interface uart_rx_ctrl_if;
  import uart_pkg::*;

  logic                 uart_in;
  logic                 rd_en;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 overrun;
  logic                 frame_err;
  logic                 parity_err;

  modport master (
    output uart_in, rd_en,
    input  rx_data, rx_valid, overrun, frame_err, parity_err
  );

  modport slave (
    input  uart_in, rd_en,
    output rx_data, rx_valid, overrun, frame_err, parity_err
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick: one-cycle pulse every DIV cycles, combinational from the counter.
// No backpressure; only Reset restarts the phase.
module uart_baud_tick #(
  parameter int DIV = 16
) (
  input  logic sysclk,
  input  logic Reset,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge sysclk) begin
    if (Reset) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive framer with one-byte holding register; rx_valid rises the cycle after the stop-bit decision tick.
// No backpressure: an unread byte is overwritten and flagged as overrun. Parity bit enabled by UART_RX_PARITY_EN.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
  ,parameter bit PARITY_ODD = PAR_EVEN
`endif
) (
  input logic           sysclk,
  input logic           Reset,
  uart_rx_ctrl_if.slave rx_if
);

  localparam int DIV  = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int PW   = $clog2(OVERSAMPLE);
  localparam int BCW  = $clog2(DATA_BITS);
  localparam int HALF = OVERSAMPLE / 2;

  localparam logic [PW-1:0]  PH_FIRST = PW'(1);
  localparam logic [PW-1:0]  PH_S0    = PW'(HALF - 1);
  localparam logic [PW-1:0]  PH_S1    = PW'(HALF);
  localparam logic [PW-1:0]  PH_DEC   = PW'(HALF + 1);
  localparam logic [PW-1:0]  PH_LAST  = PW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE      = ST_IDLE;
  localparam logic [2:0] S_START     = ST_START;
  localparam logic [2:0] S_DATA      = ST_DATA;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY    = ST_PARITY;
`endif
  localparam logic [2:0] S_STOP      = ST_STOP;
  localparam logic [2:0] S_WAIT_IDLE = ST_WAIT_IDLE;

  logic                 w_tick;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 w_rx;
  logic [2:0]           r_state;
  logic [PW-1:0]        r_ph;
  logic [PW-1:0]        w_ph_nxt;
  logic [1:0]           r_smp;
  logic [BCW-1:0]       r_bitcnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 w_dec;
  logic                 w_bit;
  logic                 w_load;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_overrun;
  logic                 r_frame_err;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_bad;
  logic                 r_parity_err;
`endif

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .sysclk (sysclk),
    .Reset  (Reset),
    .tick   (w_tick)
  );

  always_ff @(posedge sysclk) begin
    if (Reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_if.uart_in;
      r_sync2 <= r_sync1;
    end
  end

  // Samples land on phases HALF-1, HALF and HALF+1; the third is taken live, so the bit is decided on HALF+1.
  always_comb begin
    w_rx     = r_sync2;
    w_ph_nxt = (r_ph == PH_LAST) ? '0 : r_ph + PW'(1);
    w_dec    = w_tick && (r_state != S_IDLE) && (r_state != S_WAIT_IDLE) && (w_ph_nxt == PH_DEC);
    w_bit    = (r_smp[1] & r_smp[0]) | (r_smp[1] & w_rx) | (r_smp[0] & w_rx);
    w_load   = w_dec && (r_state == S_STOP);
  end

  // The detecting tick already lies inside the start bit, so it counts as phase 1.
  always_ff @(posedge sysclk) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_ph     <= '0;
      r_smp    <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= 1'b0;
`endif
    end else if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (!w_rx) begin
            r_state <= S_START;
            r_ph    <= PH_FIRST;
          end
        end
        S_WAIT_IDLE: begin
          if (w_rx) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_ph <= w_ph_nxt;
          if ((w_ph_nxt == PH_S0) || (w_ph_nxt == PH_S1)) begin
            r_smp <= {r_smp[0], w_rx};
          end
          if (w_ph_nxt == PH_DEC) begin
            case (r_state)
              S_START: begin
                r_bitcnt <= '0;
                r_state  <= w_bit ? S_IDLE : S_DATA;
              end
              S_DATA: begin
                r_shift  <= {w_bit, r_shift[DATA_BITS-1:1]};
                r_bitcnt <= r_bitcnt + BCW'(1);
                if (r_bitcnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                  r_state <= S_PARITY;
`else
                  r_state <= S_STOP;
`endif
                end
              end
`ifdef UART_RX_PARITY_EN
              S_PARITY: begin
                r_par_bad <= ((^r_shift) ^ w_bit) != PARITY_ODD;
                r_state   <= S_STOP;
              end
`endif
              S_STOP: begin
                r_state <= w_bit ? S_IDLE : S_WAIT_IDLE;
              end
              default: begin
                r_state <= S_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

  // A load in the same cycle as rd_en wins; rd_en only clears what was already there.
  always_ff @(posedge sysclk) begin
    if (Reset) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      if (w_load) begin
        r_rx_data <= r_shift;
      end
      r_rx_valid  <= w_load | (r_rx_valid & ~rx_if.rd_en);
      r_overrun   <= (w_load & r_rx_valid & ~rx_if.rd_en) | (r_overrun & ~rx_if.rd_en);
      r_frame_err <= (w_load & ~w_bit) | (r_frame_err & ~rx_if.rd_en);
`ifdef UART_RX_PARITY_EN
      r_parity_err <= (w_load & r_par_bad) | (r_parity_err & ~rx_if.rd_en);
`endif
    end
  end

  assign rx_if.rx_data   = r_rx_data;
  assign rx_if.rx_valid  = r_rx_valid;
  assign rx_if.overrun   = r_overrun;
  assign rx_if.frame_err = r_frame_err;
`ifdef UART_RX_PARITY_EN
  assign rx_if.parity_err = r_parity_err;
`else
  assign rx_if.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: table of frames checked through a scoreboard, plus hand-written corner sequences.
module tb_uart_rx_ctrl;

  localparam int CLK_HZ     = 1_600_000;
  localparam int BAUD       = 10_000;
  localparam int OVERSAMPLE = 16;
  localparam int DIV        = 10;
  localparam int BIT_CYC    = DIV * OVERSAMPLE;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Edge -> 2 sync flops -> detect register, then 152 (or 168) ticks to the stop decision; up to DIV-1 of tick phase on top.
  localparam int LAT_MIN = 3 + DIV * (OVERSAMPLE / 2 + OVERSAMPLE * (FRAME_BITS - 1));
  localparam int LAT_MAX = LAT_MIN + DIV - 1;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       pflip;
    logic       eferr;
    logic       eperr;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   t_start = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic prev_valid = 1'b0;
  exp_t sb[$];
  vec_t vecs[$];

  uart_rx_ctrl_if rif();

  uart_rx_ctrl #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE)
  ) dut (
    .sysclk (clk),
    .Reset  (rst),
    .rx_if  (rif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every new byte must match the oldest expectation and arrive in the latency window.
  always @(negedge clk) begin
    if (rif.rx_valid && !prev_valid) begin
      check("rx_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        int   lat;
        e   = sb.pop_front();
        lat = cyc - t_start;
        check("rx_data", rif.rx_data, e.data);
        check("rx_frame_err", rif.frame_err, e.ferr);
        check("rx_parity_err", rif.parity_err, e.perr);
        check("rx_overrun", rif.overrun, 0);
        n_tests++;
        if (lat < LAT_MIN || lat > LAT_MAX) begin
          n_fail++;
          $display("FAIL rx_latency: got %0d cycles, required %0d..%0d", lat, LAT_MIN, LAT_MAX);
        end
      end
    end
    prev_valid = rif.rx_valid;
  end

  task automatic hold(input logic v, input int n);
    rif.uart_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd_pulse();
    rif.rd_en = 1'b1;
    @(posedge clk);
    #1;
    rif.rd_en = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip,
                            input logic push, input logic eferr, input logic eperr);
    if (push) begin
      exp_t e;
      e.data = d;
      e.ferr = eferr;
      e.perr = eperr;
      sb.push_back(e);
    end
    t_start = cyc;
    hold(1'b0, BIT_CYC);
    for (int i = 0; i < 8; i++) hold(d[i], BIT_CYC);
`ifdef UART_RX_PARITY_EN
    hold((^d) ^ pflip, BIT_CYC);
`else
    if (pflip) $display("note: parity bit not present in this build, flip ignored");
`endif
    hold(stop, BIT_CYC);
  endtask

  task automatic add_vec(input logic [7:0] d, input logic stop, input logic pflip,
                         input logic eferr, input logic eperr);
    vec_t v;
    v.data  = d;
    v.stop  = stop;
    v.pflip = pflip;
    v.eferr = eferr;
    v.eperr = eperr;
    vecs.push_back(v);
  endtask

  initial begin
    add_vec(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef UART_RX_PARITY_EN
    add_vec(8'h07, 1'b1, 1'b1, 1'b0, 1'b1);
    add_vec(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

    rst         = 1'b1;
    rif.uart_in = 1'b1;
    rif.rd_en   = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("reset_rx_data", rif.rx_data, 0);
    check("reset_rx_valid", rif.rx_valid, 0);
    check("reset_overrun", rif.overrun, 0);
    check("reset_frame_err", rif.frame_err, 0);
    check("reset_parity_err", rif.parity_err, 0);
    rst = 1'b0;
    hold(1'b1, BIT_CYC);

    for (int i = 0; i < vecs.size(); i++) begin
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].pflip, 1'b1, vecs[i].eferr, vecs[i].eperr);
      hold(1'b1, 2 * DIV);
      check("tbl_sb_drained", sb.size(), 0);
      check("tbl_valid_held", rif.rx_valid, 1);
      rd_pulse();
      check("tbl_rd_clears_valid", rif.rx_valid, 0);
      check("tbl_rd_clears_perr", rif.parity_err, 0);
      check("tbl_rd_clears_ferr", rif.frame_err, 0);
    end

    // Read with nothing pending leaves the data register alone.
    rd_pulse();
    check("rd_empty_keeps_data", rif.rx_data, vecs[vecs.size() - 1].data);
    check("rd_empty_valid", rif.rx_valid, 0);

    // Short low glitch must be rejected silently.
    hold(1'b0, 40);
    hold(1'b1, 3 * BIT_CYC);
    check("glitch_valid", rif.rx_valid, 0);
    check("glitch_frame_err", rif.frame_err, 0);
    check("glitch_overrun", rif.overrun, 0);

    // Two frames back to back with no read: second overwrites and flags overrun.
    send_frame(8'h12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h34, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    hold(1'b1, 2 * DIV);
    check("ovr_sb_drained", sb.size(), 0);
    check("ovr_rx_data", rif.rx_data, 8'h34);
    check("ovr_valid", rif.rx_valid, 1);
    check("ovr_overrun", rif.overrun, 1);
    rd_pulse();
    check("ovr_rd_valid", rif.rx_valid, 0);
    check("ovr_rd_overrun", rif.overrun, 0);

    // Bad stop bit followed by a line held low: no new byte until the line idles high.
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    hold(1'b0, 100);
    rd_pulse();
    hold(1'b0, 2 * BIT_CYC - 101);
    check("ferr_wait_valid", rif.rx_valid, 0);
    check("ferr_wait_cleared", rif.frame_err, 0);
    check("ferr_wait_data", rif.rx_data, 8'h55);
    hold(1'b1, BIT_CYC);
    send_frame(8'h0F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    hold(1'b1, 2 * DIV);
    check("ferr_next_sb_drained", sb.size(), 0);
    rd_pulse();

    // Reset in the middle of a frame, with an unread byte and pending state.
    send_frame(8'h99, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    hold(1'b1, 2 * DIV);
    check("rst_pre_sb_drained", sb.size(), 0);
    check("rst_pre_valid", rif.rx_valid, 1);
    hold(1'b0, BIT_CYC);
    for (int i = 0; i < 4; i++) hold(i[0], BIT_CYC);
    hold(1'b1, 40);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_rx_data", rif.rx_data, 0);
    check("rst_mid_valid", rif.rx_valid, 0);
    check("rst_mid_overrun", rif.overrun, 0);
    check("rst_mid_frame_err", rif.frame_err, 0);
    check("rst_mid_parity_err", rif.parity_err, 0);
    rst = 1'b0;
    hold(1'b1, 2 * BIT_CYC);
    check("rst_no_partial", rif.rx_valid, 0);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    hold(1'b1, 2 * DIV);
    check("rst_next_sb_drained", sb.size(), 0);
    check("rst_next_data", rif.rx_data, 8'hC3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
